flash_page_loader: RTL and testbench
====================================

# flash_page_loader

Streams one 4096-byte page from the Winbond SPI flash into the on-FPGA ROM page buffer. It issues a Read Data command (0x03) with a 24-bit address, clocks in 4096 bytes MSB-first, and presents each byte on a single-cycle write strobe. It sits between the flash pins and the ROM memory array: the ROM pager raises `start` with the requested page, waits on `busy`, and marks the page resident on `done`.

## Interface
- CLK_DIV, default 1: clk cycles per SPI half-period. Value 0 behaves as 1.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset. Sampled on the clk rising edge; 0 = reset.
- start  input  1  request a page load; sampled only in IDLE.
- page  input  12  flash page number; latched on an accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the page is fully written.
- wr_en  output  1  one-cycle byte write strobe to the ROM array.
- wr_addr  output  12  byte offset within the page for wr_data.
- wr_data  output  8  received byte.
- spi_cs  output  1  flash chip select, active-low.
- spi_clk  output  1  SPI clock, mode 0 (idles low).
- spi_do  output  1  MOSI.
- spi_di  input  1  MISO.

## Operation
- Flash byte address = {page, 12'h000}. Command bytes in order:
  - 0x03
  - page[11:4]
  - {page[3:0], 4'h0}
  - 0x00
- States:
  - IDLE: on start=1, latch page, clear the bit and byte counters, drive spi_cs=0 and busy=1, go to TX_LOW.
  - TX_LOW: spi_clk=0; drive spi_do with the current command bit (MSB first). Hold CLK_DIV cycles, then go to TX_HIGH.
  - TX_HIGH: spi_clk=1 for CLK_DIV cycles; the flash samples on the rising edge. After bit 31 go to RX_LOW, otherwise return to TX_LOW.
  - RX_LOW: spi_clk=0 and spi_do=0 for CLK_DIV cycles.
  - RX_HIGH: raise spi_clk and shift spi_di into the byte register on the first cycle of the phase (the rising edge). Hold CLK_DIV cycles.
  - After the 8th bit of a byte: pulse wr_en in the next cycle with wr_data = assembled byte and wr_addr = byte count, then increment the byte count. The strobe overlaps the next RX_LOW and does not stall SPI.
  - After byte 4095 (wr_addr 12'hfff) go to FINISH instead of RX_LOW.
  - FINISH: 1 cycle, spi_clk=0, wr_en for byte 4095. Next cycle: spi_cs=1, busy=0, done=1 for one cycle, return to IDLE.
- wr_addr counts 0..4095 with no wrap. Exactly 4096 wr_en pulses per load.
- A start while busy is ignored. Changes to page during a load are ignored.
- start and done in the same cycle is impossible; start is accepted only in IDLE.

## Timing
- Reset values: spi_cs=1, spi_clk=0, spi_do=0, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, state=IDLE.
- Reset mid-load: all outputs return to reset values on the next edge, no done pulse is issued, and partial data already written stays in the ROM array.
- The flash sees CS high for at least 1 cycle between loads.
- Total SPI bits per load: 32 + 32768 = 32800, each 2·CLK_DIV cycles.
- Start accepted at edge E0. spi_cs falls after E0. done is high in cycle E0 + 2 + 2·CLK_DIV·32800.
  - CLK_DIV=1: done at E0+65602.
  - CLK_DIV=3: done at E0+196802.
- wr_en for byte n occurs 1 cycle after the rising spi_clk edge of that byte's bit 0.
- spi_do is stable for the full TX_LOW and TX_HIGH phases of each bit.

## Test plan
- Reset: hold reset=0 for 3 cycles -> spi_cs=1, spi_clk=0, busy=0, done=0, wr_en=0 every cycle. No spi_clk toggles.
- Command framing: start with page=12'h001, CLK_DIV=1 -> spi_do sampled on spi_clk rising edges reads 0x03, 0x00, 0x10, 0x00, and spi_cs stays low throughout.
- Data path: flash model returns (byte_addr[7:0] ^ 8'h5A) -> 4096 wr_en pulses with wr_addr=n and wr_data=n[7:0]^8'h5A. done occurs exactly 65602 cycles after the start edge, and spi_cs rises with it.
- Busy protection: during a page 12'h001 load, assert start with page=12'h7ff -> ignored. Address bytes stay 0x00/0x10/0x00 and a single done is produced.
- Reset mid-load: drive reset=0 after wr_en #100 -> next cycle spi_cs=1, busy=0, no further wr_en, no done. A new start with page=12'h002 re-issues the full command (address 0x002000) from wr_addr 0.
- Divider and top page: CLK_DIV=3, page=12'hfff -> spi_clk high and low phases each 3 cycles, address bytes 0xFF/0xF0/0x00, done at E0+196802.

Source files
------------

// File: rtl/flash_page_loader.sv
// flash_page_loader
// Streams one 4096-byte page out of a Winbond SPI flash into the ROM page
// buffer. A Read Data command (0x03 + 24-bit address {page, 12'h000}) is
// shifted out MSB first. Then 4096 bytes are shifted in MSB first. Each
// received byte is presented on a single-cycle write strobe.
//
// Parameters
//   CLK_DIV  clk cycles per SPI half-period (0 behaves as 1)
// Ports
//   clk      system clock
//   reset    synchronous, active-low reset
//   start    page load request, only honoured while idle
//   page     flash page number, latched when start is accepted
//   busy     high while a load is in progress
//   done     one-cycle pulse after the last byte has been written
//   wr_en    one-cycle byte write strobe to the ROM array
//   wr_addr  byte offset within the page for wr_data
//   wr_data  received byte
//   spi_cs   flash chip select, active-low
//   spi_clk  SPI clock, mode 0
//   spi_do   MOSI
//   spi_di   MISO
module flash_page_loader #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] page,
    output logic        busy,
    output logic        done,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_do,
    input  logic        spi_di
);

    localparam int unsigned DIV   = (CLK_DIV == 0) ? 1 : CLK_DIV;
    localparam int          DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        TX_LOW,
        TX_HIGH,
        RX_LOW,
        RX_HIGH,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    // Bit index within the current section: 0..31 while sending the
    // command, 0..32767 while receiving. During receive, [14:3] is the
    // byte offset and [2:0] the bit within that byte.
    logic [14:0]      bit_cnt_q, bit_cnt_d;
    logic [31:0]      cmd_q, cmd_d;
    logic [7:0]       rx_q, rx_d;

    logic             spi_cs_q, spi_clk_q, spi_do_q;
    logic             busy_q, done_q, wr_en_q;
    logic [11:0]      wr_addr_q;
    logic [7:0]       wr_data_q;

    logic             phase_end;
    logic             accept;
    logic             rx_sample;
    logic             byte_done;

    assign phase_end = (div_cnt_q == DIV_LAST);
    // The done cycle is spent in IDLE. Masking start there keeps start and
    // done from ever coinciding.
    assign accept    = (state_q == IDLE) && start && !done_q;
    // MISO is captured on the first cycle of the high phase, i.e. right
    // after the rising SPI edge.
    assign rx_sample = (state_q == RX_HIGH) && (div_cnt_q == '0);
    assign byte_done = rx_sample && (bit_cnt_q[2:0] == 3'd7);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;

        if (rx_sample) begin
            rx_d = {rx_q[6:0], spi_di};
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = TX_LOW;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    cmd_d     = {8'h03, page, 12'h000};
                end
            end
            TX_LOW: begin
                if (phase_end) begin
                    state_d   = TX_HIGH;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            TX_HIGH: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 15'd31) begin
                        state_d   = RX_LOW;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = TX_LOW;
                        bit_cnt_d = bit_cnt_q + 15'd1;
                        cmd_d     = {cmd_q[30:0], 1'b0};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            RX_LOW: begin
                if (phase_end) begin
                    state_d   = RX_HIGH;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            RX_HIGH: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 15'h7fff) begin
                        state_d = FINISH;
                    end else begin
                        state_d   = RX_LOW;
                        bit_cnt_d = bit_cnt_q + 15'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The pin-facing outputs are registered from the next state, so they
    // change together with the state and never glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            spi_cs_q  <= 1'b1;
            spi_clk_q <= 1'b0;
            spi_do_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            spi_cs_q  <= (state_d == IDLE);
            spi_clk_q <= (state_d == TX_HIGH) || (state_d == RX_HIGH);
            spi_do_q  <= ((state_d == TX_LOW) || (state_d == TX_HIGH)) ? cmd_d[31] : 1'b0;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_q == FINISH);
            wr_en_q   <= byte_done;
            if (byte_done) begin
                wr_addr_q <= bit_cnt_q[14:3];
                wr_data_q <= rx_d;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign spi_cs  = spi_cs_q;
    assign spi_clk = spi_clk_q;
    assign spi_do  = spi_do_q;

endmodule

// File: tb/tb_flash_page_loader.sv
// tb_flash_page_loader
// Drives two loaders from one clock: u_dut1 (CLK_DIV=1) serves a behavioural
// flash model that returns byte_addr[7:0] ^ 8'h5A, and u_dut3 (CLK_DIV=3)
// checks the divider and the top page.
module tb_flash_page_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_1 = 1'b0;
    logic        start_3 = 1'b0;
    logic [11:0] page = 12'h000;

    logic        busy_1, done_1, wr_en_1, spi_cs_1, spi_clk_1, spi_do_1;
    logic [11:0] wr_addr_1;
    logic [7:0]  wr_data_1;
    logic        spi_di_1 = 1'b0;

    logic        busy_3, done_3, wr_en_3, spi_cs_3, spi_clk_3, spi_do_3;
    logic [11:0] wr_addr_3;
    logic [7:0]  wr_data_3;
    logic        spi_di_3 = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flash_page_loader #(.CLK_DIV(1)) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .start   (start_1),
        .page    (page),
        .busy    (busy_1),
        .done    (done_1),
        .wr_en   (wr_en_1),
        .wr_addr (wr_addr_1),
        .wr_data (wr_data_1),
        .spi_cs  (spi_cs_1),
        .spi_clk (spi_clk_1),
        .spi_do  (spi_do_1),
        .spi_di  (spi_di_1)
    );

    flash_page_loader #(.CLK_DIV(3)) u_dut3 (
        .clk     (clk),
        .reset   (reset),
        .start   (start_3),
        .page    (page),
        .busy    (busy_3),
        .done    (done_3),
        .wr_en   (wr_en_3),
        .wr_addr (wr_addr_3),
        .wr_data (wr_data_3),
        .spi_cs  (spi_cs_3),
        .spi_clk (spi_clk_3),
        .spi_do  (spi_do_3),
        .spi_di  (spi_di_3)
    );

    // Flash model for u_dut1: records the 32 command bits on rising SPI
    // edges and shifts out data on falling edges (mode 0).
    int          fl_rises = 0;
    logic [31:0] fl_cmd = '0;
    always @(posedge spi_clk_1 or negedge spi_clk_1 or posedge spi_cs_1) begin : flash_model
        logic [23:0] a;
        logic [7:0]  b;
        int          idx;
        if (spi_cs_1 !== 1'b0) begin
            fl_rises = 0;
        end else if (spi_clk_1) begin
            if (fl_rises < 32) fl_cmd = {fl_cmd[30:0], spi_do_1};
            fl_rises++;
        end else if (fl_rises >= 32) begin
            idx = fl_rises - 32;
            a = fl_cmd[23:0] + 24'(idx / 8);
            b = a[7:0] ^ 8'h5a;
            spi_di_1 = b[3'(7 - (idx % 8))];
        end
    end

    typedef struct {
        logic [31:0] cmd;
        int rises;
        int wr_cnt;
        int first_wr_addr;
        int wr_addr_err;
        int wr_data_err;
        int wr_time_err;
        int done_cnt;
        int done_k;
        int cs_early_high;
        int busy_early_low;
        logic cs_at_done;
        logic busy_at_done;
        int hi_min, hi_max, lo_min, lo_max;
        logic post_cs, post_busy, post_clk;
        int post_wr;
        int post_done;
    } stats_t;

    // Starts one load and observes it. Cycle k is the cycle sampled by edge
    // E0+k, where E0 is the edge that accepts start. abort_at > 0 pulls
    // reset low right after that many write strobes. poke re-raises start
    // with page 12'h7ff while the command is being sent.
    task automatic run_load(input bit use3, input logic [11:0] pg, input int abort_at,
                            input bit poke, output stats_t s);
        logic c_clk, c_cs, c_busy, c_done, c_wr, c_do, pclk;
        logic [11:0] c_addr;
        logic [7:0]  c_data;
        int run, last_rise_k, limit;
        s = '{default: 0};
        s.hi_min = 1 << 30;
        s.lo_min = 1 << 30;
        limit = (use3 ? 6 : 2) * 32800 + 50;
        @(negedge clk);
        page = pg;
        if (use3) start_3 = 1'b1; else start_1 = 1'b1;
        @(posedge clk);
        #1;
        start_1 = 1'b0;
        start_3 = 1'b0;
        pclk = 1'b0;
        run = 0;
        last_rise_k = -10;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            c_clk  = use3 ? spi_clk_3 : spi_clk_1;
            c_cs   = use3 ? spi_cs_3 : spi_cs_1;
            c_busy = use3 ? busy_3 : busy_1;
            c_done = use3 ? done_3 : done_1;
            c_wr   = use3 ? wr_en_3 : wr_en_1;
            c_do   = use3 ? spi_do_3 : spi_do_1;
            c_addr = use3 ? wr_addr_3 : wr_addr_1;
            c_data = use3 ? wr_data_3 : wr_data_1;
            if (poke && k == 10) begin
                page = 12'h7ff;
                if (use3) start_3 = 1'b1; else start_1 = 1'b1;
            end
            if (poke && k == 12) begin
                start_1 = 1'b0;
                start_3 = 1'b0;
            end
            if (c_clk === pclk) begin
                run++;
            end else begin
                if (pclk) begin
                    if (run < s.hi_min) s.hi_min = run;
                    if (run > s.hi_max) s.hi_max = run;
                end else begin
                    if (run < s.lo_min) s.lo_min = run;
                    if (run > s.lo_max) s.lo_max = run;
                end
                run = 1;
                if (c_clk === 1'b1) begin
                    last_rise_k = k;
                    if (s.rises < 32) s.cmd = {s.cmd[30:0], c_do};
                    s.rises++;
                end
            end
            pclk = c_clk;
            if (c_done === 1'b1) begin
                s.done_cnt++;
                if (s.done_cnt == 1) begin
                    s.done_k = k;
                    s.cs_at_done = c_cs;
                    s.busy_at_done = c_busy;
                end
            end else if (s.done_cnt == 0) begin
                if (c_cs !== 1'b0) s.cs_early_high++;
                if (c_busy !== 1'b1) s.busy_early_low++;
            end
            if (c_wr === 1'b1) begin
                if (s.wr_cnt == 0) s.first_wr_addr = int'(c_addr);
                if (c_addr !== 12'(s.wr_cnt)) s.wr_addr_err++;
                if (!use3 && c_data !== (8'(s.wr_cnt) ^ 8'h5a)) s.wr_data_err++;
                if (last_rise_k != k - 1) s.wr_time_err++;
                s.wr_cnt++;
            end
            if (s.done_cnt > 0 && k >= s.done_k + 3) break;
            if (abort_at > 0 && s.wr_cnt == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                s.post_cs   = use3 ? spi_cs_3 : spi_cs_1;
                s.post_busy = use3 ? busy_3 : busy_1;
                s.post_clk  = use3 ? spi_clk_3 : spi_clk_1;
                if ((use3 ? wr_en_3 : wr_en_1) !== 1'b0) s.post_wr++;
                repeat (2) @(negedge clk);
                reset = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if ((use3 ? wr_en_3 : wr_en_1) !== 1'b0) s.post_wr++;
                    if ((use3 ? done_3 : done_1) !== 1'b0) s.post_done++;
                end
                break;
            end
        end
        page = 12'h000;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({spi_cs_1, spi_clk_1, spi_do_1, busy_1, done_1, wr_en_1} !== 6'b100000) begin
                failures++;
                $display("FAIL reset_ctl1 cycle %0d: got %b want 100000", i,
                         {spi_cs_1, spi_clk_1, spi_do_1, busy_1, done_1, wr_en_1});
            end
            checks++;
            if ({wr_addr_1, wr_data_1} !== 20'h0) begin
                failures++;
                $display("FAIL reset_wr1 cycle %0d: got addr %h data %h want 000 00", i, wr_addr_1, wr_data_1);
            end
            checks++;
            if ({spi_cs_3, spi_clk_3, spi_do_3, busy_3, done_3, wr_en_3} !== 6'b100000) begin
                failures++;
                $display("FAIL reset_ctl3 cycle %0d: got %b want 100000", i,
                         {spi_cs_3, spi_clk_3, spi_do_3, busy_3, done_3, wr_en_3});
            end
        end
        reset = 1'b1;
        @(negedge clk);
        $display("test_reset: 3 reset cycles observed");
    endtask

    task automatic test_command_framing();
        stats_t s;
        run_load(1'b0, 12'h001, 16, 1'b0, s);
        checks++;
        if (s.cmd !== 32'h03001000) begin
            failures++;
            $display("FAIL framing_cmd: got %h want 03001000", s.cmd);
        end
        checks++;
        if (s.cs_early_high != 0) begin
            failures++;
            $display("FAIL framing_cs_low: got %0d cs-high cycles want 0", s.cs_early_high);
        end
        checks++;
        if (s.first_wr_addr != 0 || s.wr_addr_err != 0) begin
            failures++;
            $display("FAIL framing_first_addr: got %0d (errs %0d) want 0", s.first_wr_addr, s.wr_addr_err);
        end
        $display("test_command_framing: cmd=%h", s.cmd);
    endtask

    task automatic test_data_path_and_busy();
        stats_t s;
        run_load(1'b0, 12'h001, 0, 1'b1, s);
        checks++;
        if (s.cmd !== 32'h03001000) begin
            failures++;
            $display("FAIL busy_cmd: got %h want 03001000", s.cmd);
        end
        checks++;
        if (s.wr_cnt != 4096) begin
            failures++;
            $display("FAIL data_wr_count: got %0d want 4096", s.wr_cnt);
        end
        checks++;
        if (s.wr_addr_err != 0) begin
            failures++;
            $display("FAIL data_wr_addr: got %0d errors want 0", s.wr_addr_err);
        end
        checks++;
        if (s.wr_data_err != 0) begin
            failures++;
            $display("FAIL data_wr_data: got %0d errors want 0", s.wr_data_err);
        end
        checks++;
        if (s.wr_time_err != 0) begin
            failures++;
            $display("FAIL data_wr_timing: got %0d late/early strobes want 0", s.wr_time_err);
        end
        checks++;
        if (s.done_k != 65602) begin
            failures++;
            $display("FAIL data_done_time: got E0+%0d want E0+65602", s.done_k);
        end
        checks++;
        if (s.done_cnt != 1) begin
            failures++;
            $display("FAIL busy_single_done: got %0d done pulses want 1", s.done_cnt);
        end
        checks++;
        if (s.cs_at_done !== 1'b1 || s.busy_at_done !== 1'b0) begin
            failures++;
            $display("FAIL data_done_cs_busy: got cs=%b busy=%b want cs=1 busy=0", s.cs_at_done, s.busy_at_done);
        end
        checks++;
        if (s.cs_early_high != 0 || s.busy_early_low != 0) begin
            failures++;
            $display("FAIL data_cs_busy_hold: got cs-high %0d busy-low %0d want 0 0", s.cs_early_high, s.busy_early_low);
        end
        checks++;
        if (s.hi_min != 1 || s.hi_max != 1 || s.lo_min != 1 || s.lo_max != 1) begin
            failures++;
            $display("FAIL data_phase_len: got hi %0d..%0d lo %0d..%0d want 1..1 1..1",
                     s.hi_min, s.hi_max, s.lo_min, s.lo_max);
        end
        checks++;
        if (s.rises != 32800) begin
            failures++;
            $display("FAIL data_spi_bits: got %0d rising edges want 32800", s.rises);
        end
        $display("test_data_path_and_busy: %0d strobes, done at E0+%0d", s.wr_cnt, s.done_k);
    endtask

    task automatic test_reset_mid_load();
        stats_t s;
        stats_t r;
        run_load(1'b0, 12'h001, 100, 1'b0, s);
        checks++;
        if (s.post_cs !== 1'b1 || s.post_busy !== 1'b0 || s.post_clk !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got cs=%b busy=%b clk=%b want 1 0 0", s.post_cs, s.post_busy, s.post_clk);
        end
        checks++;
        if (s.post_wr != 0) begin
            failures++;
            $display("FAIL midreset_no_wr: got %0d strobes after reset want 0", s.post_wr);
        end
        checks++;
        if (s.post_done != 0 || s.done_cnt != 0) begin
            failures++;
            $display("FAIL midreset_no_done: got %0d done pulses want 0", s.post_done + s.done_cnt);
        end
        run_load(1'b0, 12'h002, 8, 1'b0, r);
        checks++;
        if (r.cmd !== 32'h03002000) begin
            failures++;
            $display("FAIL restart_cmd: got %h want 03002000", r.cmd);
        end
        checks++;
        if (r.first_wr_addr != 0 || r.wr_addr_err != 0) begin
            failures++;
            $display("FAIL restart_addr: got first %0d errs %0d want 0 0", r.first_wr_addr, r.wr_addr_err);
        end
        checks++;
        if (r.wr_data_err != 0) begin
            failures++;
            $display("FAIL restart_data: got %0d errors want 0", r.wr_data_err);
        end
        $display("test_reset_mid_load: restart cmd=%h", r.cmd);
    endtask

    task automatic test_divider_top_page();
        stats_t s;
        run_load(1'b1, 12'hfff, 6, 1'b0, s);
        checks++;
        if (s.cmd !== 32'h03fff000) begin
            failures++;
            $display("FAIL div_cmd: got %h want 03fff000", s.cmd);
        end
        checks++;
        if (s.hi_min != 3 || s.hi_max != 3) begin
            failures++;
            $display("FAIL div_high_len: got %0d..%0d want 3..3", s.hi_min, s.hi_max);
        end
        checks++;
        if (s.lo_min != 3 || s.lo_max != 3) begin
            failures++;
            $display("FAIL div_low_len: got %0d..%0d want 3..3", s.lo_min, s.lo_max);
        end
        checks++;
        if (s.wr_time_err != 0 || s.wr_addr_err != 0) begin
            failures++;
            $display("FAIL div_wr: got timing errs %0d addr errs %0d want 0 0", s.wr_time_err, s.wr_addr_err);
        end
        checks++;
        if (s.cs_early_high != 0 || s.busy_early_low != 0) begin
            failures++;
            $display("FAIL div_cs_busy: got cs-high %0d busy-low %0d want 0 0", s.cs_early_high, s.busy_early_low);
        end
        $display("test_divider_top_page: cmd=%h high=%0d low=%0d", s.cmd, s.hi_max, s.lo_max);
    endtask

    initial begin
        test_reset();
        test_command_framing();
        test_data_path_and_busy();
        test_reset_mid_load();
        test_divider_top_page();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
